// File: rtl/riscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter
//
// Shares one byte-wide, synchronous-read RAM between the instruction-fetch
// port and the load/store data port. A granted access (byte, half or word)
// is sequenced one byte per cycle, big-endian: the byte at the base address
// ends up in the most significant position of the assembled value.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_if_req/i_if_addr   fetch request (always a word), held until o_if_ack
//   o_if_ack             one-cycle completion pulse
//   o_if_rdata/o_if_err  fetched word / error, valid while o_if_ack=1
//   i_d_req              data request, held until o_d_ack
//   i_d_we, i_d_size     1=store; size 00 byte, 01 half, 10 word, 11 illegal
//   i_d_addr, i_d_wdata  byte address, right-justified store data
//   o_d_ack              one-cycle completion pulse
//   o_d_rdata/o_d_err    right-justified zero-extended load data / error
//   o_mem_addr           RAM byte address
//   o_mem_re             RAM read strobe, i_mem_rdata valid next cycle
//   o_mem_we/o_mem_wdata RAM write strobe and byte, commits at this edge
//   i_mem_rdata          RAM read byte
//   o_busy               high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module riscv_mem_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic              i_clk,
    input  logic              i_rst,
    // fetch port
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_ack,
    output logic [31:0]       o_if_rdata,
    output logic              o_if_err,
    // data port
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [1:0]        i_d_size,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [31:0]       i_d_wdata,
    output logic              o_d_ack,
    output logic [31:0]       o_d_rdata,
    output logic              o_d_err,
    // byte RAM
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_re,
    output logic              o_mem_we,
    output logic [7:0]        o_mem_wdata,
    input  logic [7:0]        i_mem_rdata,
    // status
    output logic              o_busy
);

    localparam int unsigned       AddrExtW = ADDR_W + 1;
    localparam logic [AddrExtW-1:0] MemLimit = AddrExtW'(MEM_BYTES);

    localparam logic PortIf   = 1'b0;
    localparam logic PortData = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StAck  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State and latched transaction
    // ------------------------------------------------------------------
    state_e              r_state;
    state_e              w_state_next;
    logic                r_port;        // port owning the current access
    logic                r_last_grant;  // port granted most recently
    logic                r_we;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_len;         // bytes in the access: 1, 2 or 4
    logic [2:0]          r_cnt;         // byte counter k
    logic [31:0]         r_wdata;
    logic [31:0]         r_shift;       // load assembly, big-endian shift-in
    logic [31:0]         r_if_rdata;
    logic [31:0]         r_d_rdata;

    logic [2:0]          w_cnt_next;
    logic [31:0]         w_shift_next;
    logic                w_grant_fire;
    logic                w_load_done;

    // ------------------------------------------------------------------
    // Arbitration and grant-time decode
    // ------------------------------------------------------------------
    logic                w_grant_any;
    logic                w_grant_data;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [1:0]          w_sel_size;
    logic [2:0]          w_sel_len;
    logic                w_misalign;
    logic [AddrExtW-1:0] w_last_addr;
    logic                w_sel_err;

    always_comb begin
        w_grant_any  = i_if_req | i_d_req;
        // On a tie the port that did not win last time goes first.
        w_grant_data = i_d_req & (~i_if_req | (r_last_grant == PortIf));
        w_sel_addr   = w_grant_data ? i_d_addr : i_if_addr;
        w_sel_size   = w_grant_data ? i_d_size : 2'b10;

        case (w_sel_size)
            2'b00:   w_sel_len = 3'd1;
            2'b01:   w_sel_len = 3'd2;
            default: w_sel_len = 3'd4;
        endcase

        w_misalign = ((w_sel_size == 2'b01) && w_sel_addr[0]) ||
                     ((w_sel_size == 2'b10) && (w_sel_addr[1:0] != 2'b00));

        // One extra bit so an access running past the top of the address
        // space cannot wrap around and look in-range.
        w_last_addr = {1'b0, w_sel_addr} + AddrExtW'(w_sel_len - 3'd1);

        w_sel_err = (w_sel_size == 2'b11) || w_misalign || (w_last_addr >= MemLimit);
    end

    // ------------------------------------------------------------------
    // Byte sequencing helpers
    // ------------------------------------------------------------------
    logic        w_issue;
    logic [31:0] w_capture;
    logic [2:0]  w_byte_sel;

    always_comb begin
        w_issue    = (r_state == StRun) && (r_cnt < r_len);
        w_capture  = {r_shift[23:0], i_mem_rdata};
        // Stores go out MSB-first: byte (N-1-k) of the right-justified data.
        w_byte_sel = r_len - r_cnt - 3'd1;
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_grant_fire = 1'b0;
        w_load_done  = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_grant_any) begin
                    w_grant_fire = 1'b1;
                    // Errors skip the RAM entirely and acknowledge next cycle.
                    w_state_next = w_sel_err ? StAck : StRun;
                end
            end
            StRun: begin
                if (r_we) begin
                    if (r_cnt == r_len - 3'd1) begin
                        w_state_next = StAck;
                    end else begin
                        w_cnt_next = r_cnt + 3'd1;
                    end
                end else begin
                    // RAM data for byte k-1 arrives in cycle k; cycle N is
                    // capture-only.
                    if (r_cnt != 3'd0) begin
                        w_shift_next = w_capture;
                    end
                    if (r_cnt == r_len) begin
                        w_state_next = StAck;
                        w_load_done  = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 3'd1;
                    end
                end
            end
            StAck: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_port       <= PortIf;
            r_last_grant <= PortData;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_len        <= 3'd0;
            r_cnt        <= 3'd0;
            r_wdata      <= 32'd0;
            r_shift      <= 32'd0;
            r_if_rdata   <= 32'd0;
            r_d_rdata    <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;

            if (w_grant_fire) begin
                r_port       <= w_grant_data;
                r_last_grant <= w_grant_data;
                r_addr       <= w_sel_addr;
                r_len        <= w_sel_len;
                r_we         <= w_grant_data & i_d_we;
                r_wdata      <= w_grant_data ? i_d_wdata : 32'd0;
                r_err        <= w_sel_err;
                r_cnt        <= 3'd0;
                r_shift      <= 32'd0;
            end

            // Read data registers only change on a completed load, so they
            // hold across store and error acknowledgements.
            if (w_load_done) begin
                if (r_port == PortData) begin
                    r_d_rdata <= w_capture;
                end else begin
                    r_if_rdata <= w_capture;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        // Strobes are masked during reset so an aborted store stops writing
        // in the very cycle reset is asserted.
        o_mem_re    = w_issue & ~r_we & ~i_rst;
        o_mem_we    = w_issue &  r_we & ~i_rst;
        o_mem_addr  = w_issue ? (r_addr + ADDR_W'(r_cnt)) : '0;
        o_mem_wdata = 8'd0;
        if (w_issue && r_we) begin
            case (w_byte_sel[1:0])
                2'd0:    o_mem_wdata = r_wdata[7:0];
                2'd1:    o_mem_wdata = r_wdata[15:8];
                2'd2:    o_mem_wdata = r_wdata[23:16];
                default: o_mem_wdata = r_wdata[31:24];
            endcase
        end

        o_if_ack   = (r_state == StAck) && (r_port == PortIf) && !i_rst;
        o_if_err   = o_if_ack & r_err;
        o_if_rdata = r_if_rdata;

        o_d_ack    = (r_state == StAck) && (r_port == PortData) && !i_rst;
        o_d_err    = o_d_ack & r_err;
        o_d_rdata  = r_d_rdata;

        o_busy     = (r_state != StIdle);
    end

endmodule
